// File: rtl/fpu_mul16_sigcore_pkg.sv
// ---------------------------------------------------------------------------
// fpu_mul16_sigcore_pkg
// Shared half-precision constants, the operand type and the multiplier FSM
// state type used by the iterative fp16 significand multiplier front end.
//
// Contents:
//   fp16_t        packed {sign, exp[4:0], frac[9:0]}
//   FP16_EXPW     exponent width (5)
//   FP16_FRACW    stored fraction width (10)
//   FP16_SIGW     significand width including the hidden bit (11)
//   FP16_BIAS     exponent bias (15)
//   FP16_EXPMAX   largest finite biased exponent (30)
//   mul_state_t   IDLE / MUL / DONE
//   fp16_sig()    significand with the hidden bit restored
// ---------------------------------------------------------------------------
package fpu_mul16_sigcore_pkg;

  localparam int FP16_EXPW   = 5;
  localparam int FP16_FRACW  = 10;
  localparam int FP16_SIGW   = FP16_FRACW + 1;
  localparam int FP16_BIAS   = 15;
  localparam int FP16_EXPMAX = 30;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXPW-1:0]  exp;
    logic [FP16_FRACW-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Hidden bit is set only for normal numbers; zero and subnormals keep it 0.
  function automatic logic [FP16_SIGW-1:0] fp16_sig(input fp16_t x);
    return {(x.exp != '0), x.frac};
  endfunction

endpackage

// File: rtl/fpu_mul16_sigcore_expcalc.sv
// ---------------------------------------------------------------------------
// fpu_mul16_sigcore_expcalc
// Combinational sign and exponent path of the fp16 multiplier. Produces the
// biased exponent of the unnormalised product along with the overflow flag
// and the right-shift distance needed when the product falls below emin.
//
// Ports:
//   sign1, sign2   in   operand signs
//   exp1, exp2     in   operand biased exponents
//   sign           out  product sign
//   ofin           out  exponent overflow (sum above FP16_EXPMAX)
//   unnorm_exp     out  biased exponent, 0 when the result is subnormal
//   denorm_diff    out  shift distance below emin, saturated at DENORM_CLAMP
// ---------------------------------------------------------------------------
module fpu_mul16_sigcore_expcalc
  import fpu_mul16_sigcore_pkg::*;
#(
  parameter int DENORM_CLAMP = 22
) (
  input  logic                  sign1,
  input  logic                  sign2,
  input  logic [FP16_EXPW-1:0]  exp1,
  input  logic [FP16_EXPW-1:0]  exp2,
  output logic                  sign,
  output logic                  ofin,
  output logic [FP16_EXPW-1:0]  unnorm_exp,
  output logic [FP16_FRACW-1:0] denorm_diff
);

  // Seven signed bits cover the full range 1+1-15 .. 31+31-15.
  logic        [6:0] e1_eff;
  logic        [6:0] e2_eff;
  logic signed [6:0] sum_exp;
  logic        [6:0] neg_exp;

  assign sign = sign1 ^ sign2;

  // Subnormals share emin with exponent 1, so a zero field counts as 1.
  always_comb begin
    e1_eff  = (exp1 == '0) ? 7'd1 : {2'b00, exp1};
    e2_eff  = (exp2 == '0) ? 7'd1 : {2'b00, exp2};
    sum_exp = signed'(e1_eff + e2_eff - 7'(FP16_BIAS));
    neg_exp = 7'(-sum_exp);
  end

  // Classify the exponent sum into overflow, normal range or below emin.
  always_comb begin
    ofin        = 1'b0;
    unnorm_exp  = '0;
    denorm_diff = '0;
    if (sum_exp > signed'(7'(FP16_EXPMAX))) begin
      ofin       = 1'b1;
      unnorm_exp = '1;
    end else if (sum_exp >= 7'sd1) begin
      unnorm_exp = sum_exp[FP16_EXPW-1:0];
    end else begin
      // Beyond the clamp every product bit is shifted out anyway.
      if (neg_exp >= 7'(DENORM_CLAMP)) begin
        denorm_diff = FP16_FRACW'(DENORM_CLAMP);
      end else begin
        denorm_diff = {{(FP16_FRACW-7){1'b0}}, neg_exp};
      end
    end
  end

endmodule

// File: rtl/fpu_mul16_sigcore.sv
// ---------------------------------------------------------------------------
// fpu_mul16_sigcore
// Iterative half-precision multiplier front end. Accepts two fp16 operands
// over valid/ready, forms the exact 22-bit significand product with a
// radix-2 shift-add loop (one multiplier bit per cycle, LSB first) and
// presents the unnormalised result in the form the downstream normaliser
// consumes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (ready only in IDLE)
//   fpuIn1, fpuIn2    multiplicand / multiplier (fp16_t)
//   out_valid/out_ready result handshake
//   unnormSign        product sign
//   unnormInt         integer bits of the significand product
//   unnormFrac        PFW fractional bits of the significand product
//   unnormExp         biased exponent, 0 when subnormal
//   denormDiff        right-shift distance below emin
//   sticky            constant 0, the product is exact
//   OFin              exponent overflow
//
// Build option:
//   FPU_MUL_EARLY_OUT_EN  skip the loop for zero significands and stop once
//                         the remaining multiplier bits are all zero.
// ---------------------------------------------------------------------------
module fpu_mul16_sigcore
  import fpu_mul16_sigcore_pkg::*;
#(
  parameter int PFW          = 20,
  parameter int DENORM_CLAMP = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  fp16_t                 fpuIn1,
  input  fp16_t                 fpuIn2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  unnormSign,
  output logic [1:0]            unnormInt,
  output logic [PFW-1:0]        unnormFrac,
  output logic [FP16_EXPW-1:0]  unnormExp,
  output logic [FP16_FRACW-1:0] denormDiff,
  output logic                  sticky,
  output logic                  OFin
);

  localparam int ACCW = PFW + 2;

  mul_state_t state;
  mul_state_t state_next;

  logic [FP16_SIGW-1:0]  sig1;
  logic [FP16_SIGW-1:0]  sig2;
  logic [FP16_SIGW-1:0]  mcand;
  logic [FP16_SIGW-1:0]  mplier;
  logic [3:0]            count;
  logic [ACCW-1:0]       acc;
  logic [ACCW-1:0]       addend;
  logic                  out_valid_q;
  logic                  accept;
  logic                  handoff;
  logic                  mul_finish;

  logic                  calc_sign;
  logic                  calc_of;
  logic [FP16_EXPW-1:0]  calc_exp;
  logic [FP16_FRACW-1:0] calc_dd;
  logic                  sign_q;
  logic                  of_q;
  logic [FP16_EXPW-1:0]  exp_q;
  logic [FP16_FRACW-1:0] dd_q;

  assign sig1 = fp16_sig(fpuIn1);
  assign sig2 = fp16_sig(fpuIn2);

  fpu_mul16_sigcore_expcalc #(
    .DENORM_CLAMP (DENORM_CLAMP)
  ) u_expcalc (
    .sign1       (fpuIn1.sign),
    .sign2       (fpuIn2.sign),
    .exp1        (fpuIn1.exp),
    .exp2        (fpuIn2.exp),
    .sign        (calc_sign),
    .ofin        (calc_of),
    .unnorm_exp  (calc_exp),
    .denorm_diff (calc_dd)
  );

  assign in_ready = (state == IDLE);
  assign accept   = (state == IDLE) && in_valid;
  // Handoff only counts once out_valid is actually visible downstream.
  assign handoff  = (state == DONE) && out_valid_q && out_ready;
  assign addend   = ACCW'(mcand) << count;

`ifdef FPU_MUL_EARLY_OUT_EN
  logic                 early_zero;
  logic [FP16_SIGW-1:0] remaining;

  assign early_zero = (sig1 == '0) || (sig2 == '0);

  // Multiplier bits above the one processed this cycle; once empty, the
  // accumulator already holds the full product.
  always_comb begin
    remaining  = mplier >> (count + 4'd1);
    mul_finish = (count == 4'(FP16_FRACW)) || (remaining == '0);
  end
`else
  assign mul_finish = (count == 4'(FP16_FRACW));
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef FPU_MUL_EARLY_OUT_EN
          state_next = early_zero ? DONE : MUL;
`else
          state_next = MUL;
`endif
        end
      end
      MUL: begin
        if (mul_finish) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (handoff) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and shift-add accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      acc    <= '0;
      sign_q <= 1'b0;
      of_q   <= 1'b0;
      exp_q  <= '0;
      dd_q   <= '0;
    end else if (accept) begin
      mcand  <= sig1;
      mplier <= sig2;
      count  <= '0;
      acc    <= '0;
      sign_q <= calc_sign;
      of_q   <= calc_of;
      exp_q  <= calc_exp;
      dd_q   <= calc_dd;
    end else if (state == MUL) begin
      if (mplier[count]) begin
        acc <= acc + addend;
      end
      count <= count + 4'd1;
    end
  end

  // out_valid rises one edge after DONE is entered and falls on handoff,
  // so a new operand can only be taken the cycle after the handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (handoff) begin
      out_valid_q <= 1'b0;
    end else if (state == DONE) begin
      out_valid_q <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign unnormSign = sign_q;
  assign unnormInt  = acc[ACCW-1:PFW];
  assign unnormFrac = acc[PFW-1:0];
  assign unnormExp  = exp_q;
  assign denormDiff = dd_q;
  assign sticky     = 1'b0;
  assign OFin       = of_q;

endmodule
